minn_peak_detect: RTL and testbench
===================================

# minn_peak_detect

Peak picker for the Minn timing-metric path. Consumes the valid-qualified window-sum stream produced by the running-sum stage, finds the first local maximum that exceeds a programmable threshold, and reports its value and sample index as a one-cycle event to the frame-timing logic. It then blanks for a fixed number of samples before searching again.

## Interface
- `IN_WIDTH`, default 21: signed metric width. 16-bit samples over a 16-deep window.
- `IDX_WIDTH`, default 32: sample-index counter width.
- `WINDOW`, default 16: consecutive non-greater samples that confirm a peak. Must be ≥1.
- `BLANK`, default 64: samples ignored after a peak. 0 is allowed.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `metric_in` is valid this cycle.
- `metric_in` in IN_WIDTH signed: window-sum metric sample.
- `threshold` in IN_WIDTH signed: detection threshold. Sampled on every accepted sample.
- `peak_valid` out 1: one-cycle pulse when a peak is confirmed.
- `peak_value` out IN_WIDTH signed: metric value of the last confirmed peak.
- `peak_index` out IDX_WIDTH: sample index of the last confirmed peak.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Sample index.** `idx` counts accepted samples (`in_valid`=1). The first sample after reset has index 0. Wraps modulo 2^IDX_WIDTH.
- **Gaps.** Cycles with `in_valid`=0 change no state, counter or output, except that `peak_valid` returns to 0.
- **All comparisons are signed.**
- **States:** IDLE, TRACK, BLANK.
- **IDLE**
  - Accepted sample with `metric_in` > `threshold` (strict): go to TRACK. Set `best_val`=metric, `best_idx`=idx, `since`=0.
  - Otherwise stay in IDLE.
- **TRACK**
  - If `metric_in` > `best_val` (strict): update `best_val`/`best_idx` and clear `since`.
  - Else, if `since`==WINDOW-1: confirm the peak and enter BLANK with `blank_cnt`=0. When BLANK=0, enter IDLE instead.
  - Else: `since`++.
  - Ties keep the earliest index.
  - The threshold is not re-checked in TRACK. A falling metric still confirms the peak.
- **BLANK**
  - Each accepted sample increments `blank_cnt`.
  - On the BLANK-th sample, return to IDLE. That sample is not evaluated against the threshold.
- **Confirm.** Registers `peak_value`=`best_val` and `peak_index`=`best_idx`, and pulses `peak_valid`. Both values hold until the next confirm.
- **Widths.** `since` is $clog2(WINDOW+1) bits and `blank_cnt` is $clog2(BLANK+1) bits (minimum 1). No arithmetic is performed on the metric, so it cannot overflow.

## Timing
- **Reset values:** `peak_valid`=0, `peak_value`=0, `peak_index`=0, `busy`=0, state=IDLE, `idx`=0, `best_val`=0, `best_idx`=0, `since`=0, `blank_cnt`=0.
- **Reset mid-operation:** discards any tracked candidate and emits no pulse.
- **Peak latency:** `peak_valid` rises in the cycle after the clock edge that accepts the WINDOW-th non-greater sample following the peak sample. It is high for exactly one cycle.
- **Back-to-back:** with BLANK=0, the sample accepted in the same cycle as the confirm pulse is already evaluated in IDLE.
- **`busy`:** registered, and follows the state from the cycle after each transition.
- **Index wrap:** `idx` wraps from 2^IDX_WIDTH-1 to 0 with no special handling.
- **Throughput:** one sample per cycle, with no backpressure.

## Structure
- **Shared package `minn_pkg`:**
  - enum typedef `peak_state_t` {PK_IDLE, PK_TRACK, PK_BLANK};
  - `MINN_METRIC_WIDTH` localparam = 21, shared with the running-sum output width.
- **No sub-module.** The FSM and the three counters live in one `always_ff` plus a small combinational next-state block.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `in_valid`=1 toggling → all outputs 0, and `busy`=0 throughout.
- **Basic peak:** WINDOW=4, BLANK=8, `threshold`=100, continuous stream 0,0,50,150,300,200,100,90,80,0…
  - → `busy` rises after index 3.
  - → one `peak_valid` pulse the cycle after index 8 is accepted, with `peak_value`=300 and `peak_index`=4.
- **Tie and blanking:** same setup, stream …,150,300,300,10,10,10,10,400,… with the second crossing inside BLANK.
  - → `peak_index` is the first 300.
  - → the 400 sample is ignored.
  - → a crossing 9 samples after the confirm is detected.
- **Gaps:** repeat the basic-peak case with `in_valid` low on alternate cycles → identical `peak_value`/`peak_index`, and exactly one pulse. The pulse comes one cycle after the confirming accepted sample.
- **Negative threshold:** `threshold`=-50, stream -100,-40,-60,-70,-80,-90 → `peak_value`=-40, `peak_index`=1.
- **Reset mid-TRACK:** assert `rst` after index 5 of the basic stream, then replay the stream → no pulse before the replay. After the replay, `peak_index`=4 because the index restarts at 0.

Source files
------------

// File: rtl/minn_pkg.sv
// Shared definitions for the Minn timing-metric path.
//   MINN_METRIC_WIDTH : width of the running-sum metric (16-bit samples, 16-deep window)
//   peak_state_t      : peak-picker FSM states
package minn_pkg;

  localparam int MINN_METRIC_WIDTH = 21;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_TRACK,
    PK_BLANK
  } peak_state_t;

endpackage

// File: rtl/minn_peak_detect.sv
// Peak picker for the Minn timing metric. Finds the first local maximum of the
// valid-qualified metric stream that exceeds a threshold. A maximum counts as
// confirmed once WINDOW consecutive samples fail to beat it. The detector then
// ignores BLANK samples before it searches again.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : metric_in is valid this cycle (gaps freeze all state)
//   metric_in   : signed window-sum metric sample
//   threshold   : signed detection threshold, sampled with each accepted sample
//   peak_valid  : one-cycle pulse when a peak is confirmed
//   peak_value  : metric value of the last confirmed peak (held)
//   peak_index  : sample index of the last confirmed peak (held)
//   busy        : registered, high while the FSM is not idle
module minn_peak_detect
  import minn_pkg::*;
#(
  parameter int IN_WIDTH  = MINN_METRIC_WIDTH,
  parameter int IDX_WIDTH = 32,
  parameter int WINDOW    = 16,
  parameter int BLANK     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  metric_in,
  input  logic signed [IN_WIDTH-1:0]  threshold,
  output logic                        peak_valid,
  output logic signed [IN_WIDTH-1:0]  peak_value,
  output logic        [IDX_WIDTH-1:0] peak_index,
  output logic                        busy
);

  localparam int SINCE_W = $clog2(WINDOW + 1);
  localparam int BLANK_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

  localparam logic [SINCE_W-1:0] SINCE_LAST = SINCE_W'(WINDOW - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = (BLANK < 1) ? '0 : BLANK_W'(BLANK - 1);

  // With no blanking the confirming sample hands straight back to IDLE, so the
  // next accepted sample is already evaluated against the threshold.
  localparam peak_state_t CONFIRM_STATE = (BLANK == 0) ? PK_IDLE : PK_BLANK;

  peak_state_t                 state, state_next;
  logic        [IDX_WIDTH-1:0] idx;
  logic signed [IN_WIDTH-1:0]  best_val;
  logic        [IDX_WIDTH-1:0] best_idx;
  logic        [SINCE_W-1:0]   since, since_next;
  logic        [BLANK_W-1:0]   blank_cnt, blank_next;
  logic                        take_best;
  logic                        confirm;

  always_comb begin
    state_next = state;
    since_next = since;
    blank_next = blank_cnt;
    take_best  = 1'b0;
    confirm    = 1'b0;
    if (in_valid) begin
      case (state)
        PK_IDLE: begin
          if (metric_in > threshold) begin
            state_next = PK_TRACK;
            take_best  = 1'b1;
            since_next = '0;
          end
        end
        PK_TRACK: begin
          // Strict compare: a tie keeps the earlier index.
          if (metric_in > best_val) begin
            take_best  = 1'b1;
            since_next = '0;
          end else if (since == SINCE_LAST) begin
            confirm    = 1'b1;
            state_next = CONFIRM_STATE;
            blank_next = '0;
          end else begin
            since_next = since + 1'b1;
          end
        end
        PK_BLANK: begin
          // The last blanked sample is consumed here, not re-evaluated in IDLE.
          if (blank_cnt == BLANK_LAST) begin
            state_next = PK_IDLE;
          end else begin
            blank_next = blank_cnt + 1'b1;
          end
        end
        default: state_next = PK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PK_IDLE;
      busy       <= 1'b0;
      idx        <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      since      <= '0;
      blank_cnt  <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_index <= '0;
    end else begin
      peak_valid <= confirm;
      if (in_valid) begin
        state     <= state_next;
        busy      <= (state_next != PK_IDLE);
        idx       <= idx + 1'b1;
        since     <= since_next;
        blank_cnt <= blank_next;
        if (take_best) begin
          best_val <= metric_in;
          best_idx <= idx;
        end
        if (confirm) begin
          peak_value <= best_val;
          peak_index <= best_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_minn_peak_detect.sv
// Scoreboard bench for minn_peak_detect. Instance A: WINDOW=4, BLANK=8 with a
// narrow index so wrap-around can be reached. Instance B: WINDOW=1, BLANK=0 for
// back-to-back detection. Expected peaks are queued when the confirming sample
// is driven and popped when the DUT pulses peak_valid.
module tb_minn_peak_detect;
  import minn_pkg::*;

  localparam int IW = MINN_METRIC_WIDTH;
  localparam int XW = 6;

  typedef struct {
    int     pos;
    longint v;
    longint i;
  } plan_t;

  typedef struct {
    int  pos;
    bit  b;
  } bplan_t;

  typedef struct {
    int     cyc;
    longint v;
    longint i;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid_a, in_valid_b;
  logic signed [IW-1:0] metric, threshold;
  logic                 peak_valid_a, peak_valid_b;
  logic signed [IW-1:0] peak_value_a, peak_value_b;
  logic        [XW-1:0] peak_index_a, peak_index_b;
  logic                 busy_a, busy_b;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     stim[$];
  plan_t  plan[$];
  bplan_t bplan[$];
  exp_t   exp_a[$];
  exp_t   exp_b[$];
  bit     gaps;
  bit     tgt;

  minn_peak_detect #(.IN_WIDTH(IW), .IDX_WIDTH(XW), .WINDOW(4), .BLANK(8)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_a),
    .metric_in  (metric),
    .threshold  (threshold),
    .peak_valid (peak_valid_a),
    .peak_value (peak_value_a),
    .peak_index (peak_index_a),
    .busy       (busy_a)
  );

  minn_peak_detect #(.IN_WIDTH(IW), .IDX_WIDTH(XW), .WINDOW(1), .BLANK(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_b),
    .metric_in  (metric),
    .threshold  (threshold),
    .peak_valid (peak_valid_b),
    .peak_value (peak_value_b),
    .peak_index (peak_index_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (peak_valid_a === 1'b1) begin
      if (exp_a.size() == 0) check("a_unexpected_pulse", 1, 0);
      else begin
        e = exp_a.pop_front();
        check("a_pulse_cycle", cyc, e.cyc);
        check("a_peak_value", peak_value_a, e.v);
        check("a_peak_index", peak_index_a, e.i);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (peak_valid_b === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_pulse", 1, 0);
      else begin
        e = exp_b.pop_front();
        check("b_pulse_cycle", cyc, e.cyc);
        check("b_peak_value", peak_value_b, e.v);
        check("b_peak_index", peak_index_b, e.i);
      end
    end
  end

  task automatic feed(input bit v, input int m);
    in_valid_a = v & ~tgt;
    in_valid_b = v & tgt;
    metric     = IW'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      feed(k[0] == 1'b0, 500);
      check("rst_peak_valid", peak_valid_a, 0);
      check("rst_peak_value", peak_value_a, 0);
      check("rst_peak_index", peak_index_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_busy_b", busy_b, 0);
    end
    rst = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic add_plan(input int pos, input longint v, input longint i);
    plan_t p;
    p.pos = pos; p.v = v; p.i = i;
    plan.push_back(p);
  endtask

  task automatic add_busy(input int pos, input bit b);
    bplan_t p;
    p.pos = pos; p.b = b;
    bplan.push_back(p);
  endtask

  task automatic run_seq();
    exp_t e;
    for (int p = 0; p < stim.size(); p++) begin
      if (gaps) feed(1'b0, 9999);
      if (plan.size() > 0 && plan[0].pos == p) begin
        e.cyc = cyc + 1; e.v = plan[0].v; e.i = plan[0].i;
        if (tgt) exp_b.push_back(e); else exp_a.push_back(e);
        void'(plan.pop_front());
      end
      feed(1'b1, stim[p]);
      if (bplan.size() > 0 && bplan[0].pos == p) begin
        check($sformatf("busy_at_%0d", p), tgt ? busy_b : busy_a, bplan[0].b);
        void'(bplan.pop_front());
      end
    end
  endtask

  task automatic load_basic(input bit with_busy);
    stim = '{0, 0, 50, 150, 300, 200, 100, 90, 80, 0};
    repeat (7) stim.push_back(0);
    add_plan(8, 300, 4);
    if (with_busy)
      for (int p = 0; p < 17; p++) add_busy(p, (p >= 3 && p <= 15));
  endtask

  initial begin
    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    metric = '0; threshold = IW'(100); gaps = 1'b0; tgt = 1'b0;

    // Reset, then basic peak with busy tracked through the blanking window.
    do_reset();
    load_basic(1'b1);
    run_seq();
    check("hold_value", peak_value_a, 300);
    check("hold_index", peak_index_a, 4);

    // Reset clears held outputs.
    do_reset();

    // Tie, a crossing inside blanking, and the first post-blank sample.
    stim = '{0, 150, 300, 300, 10, 10, 10, 10, 400, 0, 0, 0, 0, 0, 400, 200, 0, 0, 0, 0};
    add_plan(6, 300, 2);
    add_plan(19, 200, 15);
    add_busy(13, 1'b1); add_busy(14, 1'b0); add_busy(15, 1'b1);
    run_seq();

    // Same basic stream with a gap before every sample.
    do_reset();
    gaps = 1'b1;
    load_basic(1'b0);
    run_seq();
    gaps = 1'b0;

    // Negative threshold.
    do_reset();
    threshold = -IW'(50);
    stim = '{-100, -40, -60, -70, -80, -90};
    repeat (8) stim.push_back(0);
    add_plan(5, -40, 1);
    add_busy(12, 1'b1); add_busy(13, 1'b0);
    run_seq();
    threshold = IW'(100);

    // Reset mid-TRACK, then replay.
    do_reset();
    stim = '{0, 0, 50, 150, 300, 200};
    add_busy(5, 1'b1);
    run_seq();
    do_reset();
    load_basic(1'b0);
    run_seq();

    // Index wrap-around.
    do_reset();
    stim.delete();
    repeat (62) stim.push_back(0);
    stim.push_back(300); stim.push_back(400);
    repeat (12) stim.push_back(0);
    stim.push_back(200);
    repeat (6) stim.push_back(0);
    add_plan(67, 400, 63);
    add_plan(80, 200, 12);
    run_seq();

    // Back-to-back with WINDOW=1, BLANK=0.
    do_reset();
    tgt = 1'b1;
    stim = '{150, 120, 200, 50, 300, 300, 0, 90, 0, 0};
    add_plan(1, 150, 0);
    add_plan(3, 200, 2);
    add_plan(5, 300, 4);
    add_busy(0, 1'b1); add_busy(1, 1'b0); add_busy(2, 1'b1); add_busy(7, 1'b0);
    run_seq();
    tgt = 1'b0;

    feed(1'b0, 0);
    feed(1'b0, 0);
    check("a_missing_pulses", exp_a.size(), 0);
    check("b_missing_pulses", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
